// File: rtl/cam_fifo_sdram_writer.sv
// Camera FIFO drain: fixed-length SDRAM write bursts into ping-pong frame banks.
// Two-entry skid buffer decouples the 1-cycle FIFO read latency from wr_ready.
module cam_fifo_sdram_writer #(
  parameter int                BURST_LEN   = 256,
  parameter int                FRAME_WORDS = 307200,
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = 'h080000
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [9:0]        data_count_r,
  output logic              rd_en,
  input  logic [15:0]       fifo_dout,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [15:0]       wr_data,
  input  logic              frame_sync,
  output logic              frame_done,
  output logic              rd_bank
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, NEXT} state_t;

  localparam logic [9:0]        BL10 = 10'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FRAME_WORDS);

  if (BURST_LEN < 1 || BURST_LEN > 512 ||
      (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bl_chk
    $error("BURST_LEN must be a power of two <= 512");
  end
  if (FRAME_WORDS % BURST_LEN != 0) begin : g_fw_chk
    $error("FRAME_WORDS must be a multiple of BURST_LEN");
  end
  if (longint'(BANK_OFFSET) + longint'(FRAME_WORDS) >=
      (longint'(1) << ADDR_W)) begin : g_aw_chk
    $error("BANK_OFFSET + FRAME_WORDS exceeds address space");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [9:0]        rd_left_q, rd_left_d;
  logic [9:0]        wr_left_q, wr_left_d;
  logic [15:0]       buf0_q, buf0_d;
  logic [15:0]       buf1_q, buf1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              sync_q, sync_d;
  logic              done_q, done_d;

  logic              pop;
  logic [1:0]        held;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] eff_off;
  logic [ADDR_W-1:0] next_off;

  assign cmd_valid  = (state_q == CMD);
  assign cmd_addr   = cmd_addr_q;
  assign wr_valid   = (cnt_q != 2'd0);
  assign wr_data    = buf0_q;
  assign frame_done = done_q;
  assign rd_bank    = rd_bank_q;

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    cmd_addr_d = cmd_addr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    sync_d     = sync_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    eff_off    = frame_sync ? '0 : offset_q;
    next_off   = offset_q + BL_A;
    pop        = wr_valid & wr_ready;
    // words in flight after this cycle's pop, before any new read
    held       = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    unique case (state_q)
      IDLE: begin
        offset_d = eff_off;
        if (data_count_r >= BL10) begin
          cmd_addr_d = (wr_bank_q ? BANK_OFFSET : '0) + eff_off;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (frame_sync) sync_d = 1'b1;
        if (cmd_ready) begin
          rd_left_d = BL10;
          wr_left_d = BL10;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (frame_sync) sync_d = 1'b1;
        if (rd_left_q != 10'd0 && held < 2'd2) begin
          rd_en     = 1'b1;
          rd_left_d = rd_left_q - 10'd1;
        end
        if (pop) begin
          wr_left_d = wr_left_q - 10'd1;
          if (wr_left_q == 10'd1) state_d = NEXT;
        end
      end
      NEXT: begin
        sync_d  = 1'b0;
        state_d = IDLE;
        if (next_off == FW_A) begin
          offset_d  = '0;
          done_d    = 1'b1;
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
        end else if (sync_q || frame_sync) begin
          offset_d = '0;
        end else begin
          offset_d = next_off;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    slot   = cnt_q - {1'b0, pop};
    if (pop) buf0_d = buf1_q;
    if (pend_q) begin
      if (slot == 2'd0) buf0_d = fifo_dout;
      else              buf1_d = fifo_dout;
    end
    cnt_d  = slot + {1'b0, pend_q};
    pend_d = rd_en;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      offset_q   <= '0;
      cmd_addr_q <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      cmd_addr_q <= cmd_addr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_cam_fifo_sdram_writer.sv
// Bench for cam_fifo_sdram_writer: FIFO source model, read/consume queue,
// frame/bank address model and randomized handshake back-pressure.
module tb_cam_fifo_sdram_writer;

  localparam int              BL = 256;
  localparam int              FW = 2048;
  localparam int              AW = 22;
  localparam logic [AW-1:0]   BO = 22'h080000;

  logic          clk_100 = 1'b0;
  logic          rst_n;
  logic [9:0]    data_count_r;
  logic          rd_en;
  logic [15:0]   fifo_dout = '0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_data;
  logic          frame_sync;
  logic          frame_done;
  logic          rd_bank;

  always #5 clk_100 = ~clk_100;

  cam_fifo_sdram_writer #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .BANK_OFFSET(BO)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .data_count_r(data_count_r),
    .rd_en(rd_en), .fifo_dout(fifo_dout), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .frame_sync(frame_sync),
    .frame_done(frame_done), .rd_bank(rd_bank)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO source: an endless counting stream with 1-cycle read latency
  logic [15:0] src = '0;
  always @(posedge clk_100) begin
    if (rd_en) begin
      fifo_dout <= src;
      src       <= src + 16'd1;
    end
  end

  bit rnd = 0;
  initial begin
    wr_ready  = 1'b0;
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk_100);
      #1;
      wr_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // reference model state
  logic [15:0]   exp_q[$];
  int            m_off = 0;
  bit            m_bank = 0;
  bit            m_rd_bank = 1;
  bit            sync_req = 0;
  int            exp_fd = 0, fd_cnt = 0;
  int            ncmd = 0, nbursts = 0;
  int            wcnt = 0, rcnt = 0, busy = 0, cyc = 0, first_cyc = 0;
  bit            stall = 0, stall_any = 0, cmd_wait = 0, prev_fd = 0;
  logic [15:0]   stall_data = '0;
  logic [AW-1:0] hold_addr = '0, last_cmd = '0;

  function automatic logic [AW-1:0] exp_addr();
    return (m_bank ? BO : '0) + AW'(m_off);
  endfunction

  task automatic end_burst();
    check("rd_count", rcnt, BL);
    if (!stall_any) check("gapless", cyc - first_cyc, BL - 1);
    m_off += BL;
    if (m_off == FW) begin
      m_off     = 0;
      exp_fd++;
      m_rd_bank = m_bank;
      m_bank    = ~m_bank;
    end else if (sync_req) begin
      m_off = 0;
    end
    sync_req = 0;
    nbursts++;
  endtask

  always @(negedge clk_100) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_off = 0; m_bank = 0; m_rd_bank = 1; sync_req = 0;
      stall = 0; cmd_wait = 0; prev_fd = 0;
      ncmd = nbursts; wcnt = 0; rcnt = 0;
    end else begin
      if (cmd_valid || rd_en) busy++;
      if (frame_sync) begin
        if (cmd_valid || ncmd > nbursts) sync_req = 1;
        else m_off = 0;
      end
      if (cmd_valid) begin
        if (cmd_wait) check("cmd_hold", cmd_addr, hold_addr);
        if (cmd_ready) begin
          check("cmd_addr", cmd_addr, exp_addr());
          last_cmd = cmd_addr;
          ncmd++;
          wcnt = 0; rcnt = 0; stall_any = 0; cmd_wait = 0;
        end else begin
          cmd_wait  = 1;
          hold_addr = cmd_addr;
        end
      end
      if (stall && wr_valid) check("wr_hold", wr_data, stall_data);
      stall      = wr_valid && !wr_ready;
      stall_data = wr_data;
      if (stall) stall_any = 1;
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) check("wr_extra", 1, 0);
        else check("wr_data", wr_data, exp_q.pop_front());
        if (wcnt == 0) first_cyc = cyc;
        wcnt++;
        if (wcnt == BL) end_burst();
      end
      if (rd_en) begin
        exp_q.push_back(src);
        rcnt++;
        check("outstanding", exp_q.size() <= 2, 1);
      end
      if (frame_done) begin
        fd_cnt++;
        check("fd_width", prev_fd, 0);
      end
      prev_fd = frame_done;
    end
  end

  task automatic tick();
    @(negedge clk_100);
    #1;
  endtask

  task automatic wait_bursts(int n);
    int target = nbursts + n;
    int t = 0;
    while (nbursts < target && t < 4000 * n) begin tick(); t++; end
    if (nbursts < target) check("burst_timeout", nbursts, target);
  endtask

  task automatic wait_cmd();
    int t = 0;
    while (ncmd <= nbursts && t < 2000) begin tick(); t++; end
    if (ncmd <= nbursts) check("cmd_timeout", ncmd, nbursts + 1);
  endtask

  task automatic wait_words(int n);
    int t = 0;
    while (!(ncmd > nbursts && wcnt >= n) && t < 4000) begin tick(); t++; end
    if (!(ncmd > nbursts && wcnt >= n)) check("word_timeout", wcnt, n);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_bank"}, rd_bank, 1);
  endtask

  int b0;

  initial begin
    rst_n        = 1'b0;
    data_count_r = '0;
    frame_sync   = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    @(posedge clk_100); #1;
    rst_n = 1'b1;

    data_count_r = 10'd255;
    b0 = busy;
    repeat (1000) tick();
    check("empty_guard", busy - b0, 0);

    @(posedge clk_100); #1;
    data_count_r = 10'd256;
    wait_bursts(1);
    wait_cmd();
    check("second_cmd", last_cmd, 'h100);
    wait_bursts(1);

    rnd = 1;
    wait_bursts(2);
    rnd = 0;

    wait_bursts(4);
    repeat (4) tick();
    check("fd_frame1", fd_cnt, 1);
    check("fd_model1", fd_cnt, exp_fd);
    check("rd_bank_f1", rd_bank, 0);
    wait_cmd();
    check("bank1_cmd", last_cmd, 'h080000);
    wait_bursts(8);
    repeat (4) tick();
    check("fd_frame2", fd_cnt, 2);
    check("rd_bank_f2", rd_bank, m_rd_bank);
    check("rd_bank_f2c", rd_bank, 1);

    wait_bursts(5);
    wait_words(50);
    check("sync_burst", last_cmd, 'h500);
    b0 = fd_cnt;
    @(posedge clk_100); #1;
    frame_sync = 1'b1;
    @(posedge clk_100); #1;
    frame_sync = 1'b0;
    wait_bursts(1);
    wait_cmd();
    check("sync_next_cmd", last_cmd, 0);
    repeat (4) tick();
    check("sync_no_fd", fd_cnt, b0);
    check("sync_bank", rd_bank, 1);

    wait_words(100);
    @(posedge clk_100); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk_100);
    #1;
    rst_n = 1'b1;
    wait_cmd();
    check("rst_cmd", last_cmd, 0);
    wait_bursts(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
